// File: rtl/block_mem_pkg.sv
// ---------------------------------------------------------------------------
// block_mem_pkg
//   Shared types and sizing helpers for the block memory responder.
//   - resp_state_t : responder FSM state encoding.
//   - DEF_*        : default configuration of the responder.
//   - BEATS, BEAT_IDX_W, BLK_OFFSET_W : derived sizes for the default config.
//   - calc_* functions derive the same values for any parameter set.
// ---------------------------------------------------------------------------
package block_mem_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    RBEAT = 3'd2,
    WBEAT = 3'd3,
    DONE  = 3'd4
  } resp_state_t;

  localparam int DEF_ADDR_WIDTH       = 64;
  localparam int DEF_BLOCK_WIDTH      = 512;
  localparam int DEF_WORD_WIDTH       = 64;
  localparam int DEF_MEM_DEPTH_BLOCKS = 1024;
  localparam int DEF_READ_LATENCY     = 4;

  // Words per block.
  function automatic int calc_beats(input int block_width, input int word_width);
    return block_width / word_width;
  endfunction

  // Bits needed to select one beat within a block.
  function automatic int calc_beat_idx_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // Byte-offset bits inside one block (ignored in the request address).
  function automatic int calc_blk_offset_w(input int block_width);
    return $clog2(block_width / 8);
  endfunction

  // Shared phase counter must reach max(latency-1, beats).
  function automatic int calc_cnt_w(input int read_latency, input int beats);
    int m;
    m = (read_latency > beats) ? read_latency : beats;
    return $clog2(m + 1);
  endfunction

  localparam int BEATS        = calc_beats(DEF_BLOCK_WIDTH, DEF_WORD_WIDTH);
  localparam int BEAT_IDX_W   = calc_beat_idx_w(BEATS);
  localparam int BLK_OFFSET_W = calc_blk_offset_w(DEF_BLOCK_WIDTH);

endpackage

// File: rtl/block_mem_array.sv
// ---------------------------------------------------------------------------
// block_mem_array
//   Single-port word RAM backing the responder. Synchronous write, registered
//   read with one cycle of latency (read-before-write on the same address).
//   Contents are never reset.
// Ports
//   clk    in  1           clock, rising edge
//   we     in  1           write enable
//   addr   in  AW          word address
//   wdata  in  WORD_WIDTH  write data
//   rdata  out WORD_WIDTH  read data, valid the cycle after addr is presented
// ---------------------------------------------------------------------------
module block_mem_array #(
  parameter int WORD_WIDTH = 64,
  parameter int DEPTH      = 8192,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [WORD_WIDTH-1:0] wdata,
  output logic [WORD_WIDTH-1:0] rdata
);

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/block_mem_responder.sv
// ---------------------------------------------------------------------------
// block_mem_responder
//   Memory-side responder for block refill / write-back. Accepts a read or
//   write start with a byte address, waits READ_LATENCY cycles, then moves one
//   BLOCK_WIDTH block to/from a word-wide RAM one beat per cycle and pulses
//   o_axi_done for one cycle.
// Optional feature
//   BLOCK_MEM_PROTO_CHECK_EN : adds the sticky o_proto_err output and its
//   checking logic. Without it the port does not exist.
// Ports
//   i_clk              in  1            clock, rising edge
//   i_arst_n           in  1            synchronous active-low reset
//   i_axi_addr         in  ADDR_WIDTH   request byte address
//   i_data_block       in  BLOCK_WIDTH  write-back data
//   i_axi_write_start  in  1            write request (level)
//   i_axi_read_start   in  1            read request (level)
//   o_axi_done         out 1            one-cycle completion pulse
//   o_data_block       out BLOCK_WIDTH  last completed read block
//   o_busy             out 1            transaction in progress
//   o_proto_err        out 1            sticky protocol error (optional)
// ---------------------------------------------------------------------------
module block_mem_responder
  import block_mem_pkg::*;
#(
  parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
  parameter int BLOCK_WIDTH      = DEF_BLOCK_WIDTH,
  parameter int WORD_WIDTH       = DEF_WORD_WIDTH,
  parameter int MEM_DEPTH_BLOCKS = DEF_MEM_DEPTH_BLOCKS,
  parameter int READ_LATENCY     = DEF_READ_LATENCY
) (
  input  logic                   i_clk,
  input  logic                   i_arst_n,
  input  logic [ADDR_WIDTH-1:0]  i_axi_addr,
  input  logic [BLOCK_WIDTH-1:0] i_data_block,
  input  logic                   i_axi_write_start,
  input  logic                   i_axi_read_start,
  output logic                   o_axi_done,
  output logic [BLOCK_WIDTH-1:0] o_data_block,
  output logic                   o_busy
`ifdef BLOCK_MEM_PROTO_CHECK_EN
  ,
  output logic                   o_proto_err
`endif
);

  localparam int NUM_BEATS  = calc_beats(BLOCK_WIDTH, WORD_WIDTH);
  localparam int BEAT_SEL_W = calc_beat_idx_w(NUM_BEATS);
  localparam int OFFSET_W   = calc_blk_offset_w(BLOCK_WIDTH);
  localparam int BLK_IDX_W  = $clog2(MEM_DEPTH_BLOCKS);
  localparam int RAM_DEPTH  = MEM_DEPTH_BLOCKS * NUM_BEATS;
  localparam int RAM_AW     = $clog2(RAM_DEPTH);
  localparam int CNT_W      = calc_cnt_w(READ_LATENCY, NUM_BEATS);

  localparam logic [CNT_W-1:0] LAT_LAST   = CNT_W'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] RBEAT_LAST = CNT_W'(NUM_BEATS);
  localparam logic [CNT_W-1:0] WBEAT_LAST = CNT_W'(NUM_BEATS - 1);

  resp_state_t state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   armed_reg;
  logic                   op_wr_reg;
  logic [BLK_IDX_W-1:0]   blk_reg;
  logic [BLOCK_WIDTH-1:0] wr_block_reg;
  logic [BLOCK_WIDTH-1:0] stage_reg;
  logic [BLOCK_WIDTH-1:0] data_block_reg;
  logic [BLOCK_WIDTH-1:0] merged;

  logic                   start_any;
  logic                   accept;
  logic                   capture;
  logic [CNT_W-1:0]       cap_idx;
  logic [BEAT_SEL_W-1:0]  beat_idx;
  logic [WORD_WIDTH-1:0]  wr_words [NUM_BEATS];

  logic                   ram_we;
  logic [RAM_AW-1:0]      ram_addr;
  logic [WORD_WIDTH-1:0]  ram_wdata;
  logic [WORD_WIDTH-1:0]  ram_rdata;

  // Offset bits and bits above the wrapped block index do not address RAM.
  logic unused_addr;
  assign unused_addr = ^i_axi_addr;

  assign start_any = i_axi_write_start | i_axi_read_start;
  assign accept    = (state_reg == IDLE) & armed_reg & start_any;

  // During a beat phase the counter value is the beat number being issued.
  // In RBEAT's final cycle it equals NUM_BEATS; the truncated address then
  // issues a harmless read whose data is never captured.
  assign beat_idx  = BEAT_SEL_W'(cnt_reg);
  assign ram_addr  = RAM_AW'(blk_reg) * RAM_AW'(NUM_BEATS) + RAM_AW'(beat_idx);
  assign ram_wdata = wr_words[beat_idx];

  // Read data returned in RBEAT cycle k belongs to beat k-1.
  assign capture = (state_reg == RBEAT) && (cnt_reg != '0);
  assign cap_idx = cnt_reg - CNT_W'(1);

  generate
    for (genvar gi = 0; gi < NUM_BEATS; gi++) begin : g_beat
      assign wr_words[gi] = wr_block_reg[gi*WORD_WIDTH +: WORD_WIDTH];
      assign merged[gi*WORD_WIDTH +: WORD_WIDTH] =
        (capture && (cap_idx == CNT_W'(gi))) ? ram_rdata
                                             : stage_reg[gi*WORD_WIDTH +: WORD_WIDTH];
    end
  endgenerate

  block_mem_array #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH      (RAM_DEPTH),
    .AW         (RAM_AW)
  ) u_array (
    .clk   (i_clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_arst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and RAM write strobe.
  always_comb begin
    state_next = state_reg;
    ram_we     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          if (READ_LATENCY == 0) begin
            state_next = i_axi_write_start ? WBEAT : RBEAT;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == LAT_LAST) begin
          state_next = op_wr_reg ? WBEAT : RBEAT;
        end
      end
      RBEAT: begin
        if (cnt_reg == RBEAT_LAST) begin
          state_next = DONE;
        end
      end
      WBEAT: begin
        ram_we = 1'b1;
        if (cnt_reg == WBEAT_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One counter serves every phase: it restarts whenever the state changes.
  always_comb begin
    cnt_next = cnt_reg + CNT_W'(1);
    if ((state_next != state_reg) || (state_reg == IDLE)) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_arst_n) begin
      cnt_reg        <= '0;
      armed_reg      <= 1'b1;
      op_wr_reg      <= 1'b0;
      blk_reg        <= '0;
      wr_block_reg   <= '0;
      stage_reg      <= '0;
      data_block_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
      // armed blocks a start still held from the previous transaction.
      if (accept) begin
        armed_reg <= 1'b0;
        op_wr_reg <= i_axi_write_start;
        blk_reg   <= i_axi_addr[OFFSET_W +: BLK_IDX_W];
        if (i_axi_write_start) begin
          wr_block_reg <= i_data_block;
        end
      end else if (!start_any) begin
        armed_reg <= 1'b1;
      end
      if (capture) begin
        stage_reg <= merged;
      end
      // Publish the assembled block on entry to DONE from a read.
      if ((state_reg == RBEAT) && (cnt_reg == RBEAT_LAST)) begin
        data_block_reg <= merged;
      end
    end
  end

  assign o_axi_done   = (state_reg == DONE);
  assign o_busy       = (state_reg != IDLE);
  assign o_data_block = data_block_reg;

`ifdef BLOCK_MEM_PROTO_CHECK_EN
  logic wr_prev_reg;
  logic rd_prev_reg;
  logic proto_err_reg;
  logic start_rise;
  logic addr_hi_nz;

  assign start_rise = (i_axi_write_start & ~wr_prev_reg) | (i_axi_read_start & ~rd_prev_reg);
  assign addr_hi_nz = (i_axi_addr >> (OFFSET_W + BLK_IDX_W)) != '0;

  always_ff @(posedge i_clk) begin
    if (!i_arst_n) begin
      wr_prev_reg   <= 1'b0;
      rd_prev_reg   <= 1'b0;
      proto_err_reg <= 1'b0;
    end else begin
      wr_prev_reg <= i_axi_write_start;
      rd_prev_reg <= i_axi_read_start;
      if ((accept & i_axi_write_start & i_axi_read_start) |
          (start_rise & o_busy) |
          (accept & addr_hi_nz)) begin
        proto_err_reg <= 1'b1;
      end
    end
  end

  assign o_proto_err = proto_err_reg;
`endif

endmodule

// File: tb/tb_block_mem_responder.sv
module tb_block_mem_responder;
  localparam int AW = 64;
  localparam int BW = 512;
  localparam int WW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] addr0, addr1;
  logic [BW-1:0] din0, din1;
  logic          wr0, rd0, wr1, rd1;
  logic          done0, done1, busy0, busy1;
  logic [BW-1:0] blk0, blk1;
`ifdef BLOCK_MEM_PROTO_CHECK_EN
  logic          err0, err1;
`endif

  int checks   = 0;
  int failures = 0;
  bit sel      = 1'b0;

  logic          cur_done, cur_busy;
  logic [BW-1:0] cur_blk;
  assign cur_done = sel ? done1 : done0;
  assign cur_busy = sel ? busy1 : busy0;
  assign cur_blk  = sel ? blk1  : blk0;

  block_mem_responder #(
    .ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .WORD_WIDTH(WW),
    .MEM_DEPTH_BLOCKS(1024), .READ_LATENCY(4)
  ) u_dut (
    .i_clk(clk), .i_arst_n(rst_n), .i_axi_addr(addr0), .i_data_block(din0),
    .i_axi_write_start(wr0), .i_axi_read_start(rd0),
    .o_axi_done(done0), .o_data_block(blk0), .o_busy(busy0)
`ifdef BLOCK_MEM_PROTO_CHECK_EN
    , .o_proto_err(err0)
`endif
  );

  block_mem_responder #(
    .ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .WORD_WIDTH(WW),
    .MEM_DEPTH_BLOCKS(16), .READ_LATENCY(0)
  ) u_dut_rl0 (
    .i_clk(clk), .i_arst_n(rst_n), .i_axi_addr(addr1), .i_data_block(din1),
    .i_axi_write_start(wr1), .i_axi_read_start(rd1),
    .o_axi_done(done1), .o_data_block(blk1), .o_busy(busy1)
`ifdef BLOCK_MEM_PROTO_CHECK_EN
    , .o_proto_err(err1)
`endif
  );

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Beat k = base + k*0x1111.
  function automatic logic [BW-1:0] pat(input logic [63:0] base);
    logic [BW-1:0] r;
    r = '0;
    for (int k = 0; k < block_mem_pkg::BEATS; k++) begin
      r[k*WW +: WW] = base + 64'(k) * 64'h1111;
    end
    return r;
  endfunction

  task automatic drive(input bit w, input bit r, input logic [AW-1:0] a, input logic [BW-1:0] d);
    if (sel) begin
      wr1 = w; rd1 = r; addr1 = a; din1 = d;
    end else begin
      wr0 = w; rd0 = r; addr0 = a; din0 = d;
    end
  endtask

  // exp_n: clock edges after the accept edge at which done is first seen.
  task automatic run_txn(input string tag, input bit w, input bit r,
                         input logic [AW-1:0] a, input logic [BW-1:0] d,
                         input int exp_n, input bit hold);
    int n;
    int busy_cnt;
    bit found;
    drive(w, r, a, d);
    @(posedge clk); #1;
    n = 0; busy_cnt = 0; found = 1'b0;
    while (!found && n <= 40) begin
      if (cur_busy) busy_cnt++;
      if (cur_done) begin
        found = 1'b1;
      end else begin
        @(posedge clk); #1;
        n++;
      end
    end
    check({tag, "_lat"}, BW'(n), BW'(exp_n));
    check({tag, "_busy_cycles"}, BW'(busy_cnt), BW'(exp_n + 1));
    if (!hold) drive(1'b0, 1'b0, a, d);
    @(posedge clk); #1;
    check({tag, "_idle_after"}, BW'({cur_busy, cur_done}), BW'(0));
    $display("txn %s addr=%0h lat=%0d busy=%0d", tag, a, n, busy_cnt);
  endtask

  logic [BW-1:0] pat_a, pat_b, pat_c, pat_d;
  int bad;

  initial begin
    pat_a = pat(64'hA5A5_A5A5_0000_0000);
    pat_b = pat(64'hB0B0_0000_0000_B000);
    pat_c = pat(64'hC3C3_C3C3_C3C3_0000);
    pat_d = pat(64'hD00D_0000_0000_0000);
    rst_n = 1'b0;
    wr0 = 0; rd0 = 0; addr0 = '0; din0 = '0;
    wr1 = 0; rd1 = 0; addr1 = '0; din1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", blk0, '0);
    check("rst_busy", BW'(busy0), BW'(0));
    check("rst_done", BW'(done0), BW'(0));
`ifdef BLOCK_MEM_PROTO_CHECK_EN
    check("rst_err", BW'(err0), BW'(0));
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: write then read back at 0x1040
    run_txn("t1_write", 1, 0, 64'h1040, pat_a, 12, 0);
    check("t1_write_keeps_out", blk0, '0);
    run_txn("t1_read", 0, 1, 64'h1040, '0, 13, 0);
    check("t1_read_data", blk0, pat_a);
`ifdef BLOCK_MEM_PROTO_CHECK_EN
    check("t1_no_err", BW'(err0), BW'(0));
`endif

    // 2: start held high after done must not retrigger
    run_txn("t2_hold", 0, 1, 64'h1040, '0, 13, 1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (busy0 || done0) bad++;
    end
    check("t2_no_retrigger", BW'(bad), BW'(0));
    drive(1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;

    // 3: both starts together -> write wins
    run_txn("t3_both", 1, 1, 64'h80, pat_b, 12, 0);
    check("t3_out_unchanged", blk0, pat_a);
`ifdef BLOCK_MEM_PROTO_CHECK_EN
    check("t3_err_set", BW'(err0), BW'(1));
`endif
    run_txn("t3_readback", 0, 1, 64'h80, '0, 13, 0);
    check("t3_data", blk0, pat_b);

    // 4: block index wraps at 1024
    run_txn("t4_write0", 1, 0, 64'h0, pat_c, 12, 0);
    run_txn("t4_read_wrap", 0, 1, 64'h10000, '0, 13, 0);
    check("t4_data", blk0, pat_c);

    // 5: reset during RBEAT
    drive(1'b0, 1'b1, 64'h1040, '0);
    @(posedge clk); #1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    check("t5_in_rbeat", BW'(busy0), BW'(1));
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 64'h1040, '0);
    @(posedge clk); #1;
    check("t5_rst_data", blk0, '0);
    check("t5_rst_busy_done", BW'({busy0, done0}), BW'(0));
`ifdef BLOCK_MEM_PROTO_CHECK_EN
    check("t5_rst_err", BW'(err0), BW'(0));
`endif
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done0 || busy0) bad++;
    end
    check("t5_no_done", BW'(bad), BW'(0));
    run_txn("t5_read_after", 0, 1, 64'h1040, '0, 13, 0);
    check("t5_data", blk0, pat_a);

    // 6: READ_LATENCY=0 instance
    sel = 1'b1;
    run_txn("t6_write", 1, 0, 64'h40, pat_d, 8, 0);
    run_txn("t6_read", 0, 1, 64'h40, '0, 9, 0);
    check("t6_data", blk1, pat_d);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
